// File: rtl/mips_cpu_div_ctrl_if.sv
// Divider bus between mips_cpu_div_ctrl (master) and mips_cpu_divideru (slave).
// The master launches a divide and the slave returns a level done plus results.
interface mips_cpu_div_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             div_start;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic             div_done;
  logic             div_dbz;

  modport master (
    output div_start,
    output div_dividend,
    output div_divisor,
    input  div_quotient,
    input  div_remainder,
    input  div_done,
    input  div_dbz
  );

  modport slave (
    input  div_start,
    input  div_dividend,
    input  div_divisor,
    output div_quotient,
    output div_remainder,
    output div_done,
    output div_dbz
  );
endinterface

// File: rtl/mips_cpu_div_ctrl.sv
// DIV/DIVU sequencer and HI/LO register owner.
// The unsigned divider is fed operand magnitudes, and the results are sign-corrected
// into LO (quotient) and HI (remainder). MTHI/MTLO and the CPU stall are also handled here.
// Optional macro MIPS_DIV_DBZ_STICKY_EN adds a dbz_sticky output. With it, a
// divide-by-zero writes hi=dividend and lo=all ones.
module mips_cpu_div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi_en,
  input  logic             mtlo_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
`ifdef MIPS_DIV_DBZ_STICKY_EN
  output logic             dbz_sticky,
`endif
  mips_cpu_div_ctrl_if.master div
);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StGuard,
    StWait,
    StFixup
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] dividend_q, divisor_q;
  logic             q_neg_q, r_neg_q;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // New divides are only taken in IDLE; signed operands become unsigned magnitudes
  assign accept = (state_q == StIdle) && op_valid;
  assign a_neg  = op_signed && op_a[WIDTH-1];
  assign b_neg  = op_signed && op_b[WIDTH-1];
  assign a_mag  = a_neg ? -op_a : op_a;
  assign b_mag  = b_neg ? -op_b : op_b;

  assign busy              = (state_q != StIdle);
  assign stall             = busy && (op_valid || mthi_en || mtlo_en || hilo_rd);
  assign hi                = hi_q;
  assign lo                = lo_q;
  assign div.div_start     = (state_q == StLaunch);
  assign div.div_dividend  = dividend_q;
  assign div.div_divisor   = divisor_q;

`ifdef MIPS_DIV_DBZ_STICKY_EN
  logic [WIDTH-1:0] a_raw_q;
  logic             sticky_q;

  assign dbz_sticky = sticky_q;

  // Raw dividend for the divide-by-zero HI value; sticky flag tracks the last outcome
  always_ff @(posedge clk) begin
    if (reset) begin
      a_raw_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      if (accept) begin
        a_raw_q <= op_a;
      end
      if ((state_q == StIdle) && (mthi_en || mtlo_en)) begin
        sticky_q <= 1'b0;
      end else if (state_q == StFixup) begin
        sticky_q <= div.div_dbz;
      end
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: GUARD spends one cycle ignoring a done left over from the previous op
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (op_valid) state_d = StLaunch;
      StLaunch: state_d = StGuard;
      StGuard:  state_d = StWait;
      StWait:   if (div.div_done) state_d = StFixup;
      StFixup:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // HI/LO next value: MT* writes in IDLE, sign-corrected results in FIXUP
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == StIdle) begin
      if (mthi_en) hi_d = wdata;
      if (mtlo_en) lo_d = wdata;
    end else if (state_q == StFixup) begin
      if (!div.div_dbz) begin
        lo_d = q_neg_q ? -div.div_quotient  : div.div_quotient;
        hi_d = r_neg_q ? -div.div_remainder : div.div_remainder;
`ifdef MIPS_DIV_DBZ_STICKY_EN
      end else begin
        hi_d = a_raw_q;
        lo_d = '1;
`endif
      end
    end
  end

  // Datapath registers: HI/LO and the operands/signs latched on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q       <= '0;
      lo_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (accept) begin
        dividend_q <= a_mag;
        divisor_q  <= b_mag;
        q_neg_q    <= a_neg ^ b_neg;
        r_neg_q    <= a_neg;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_div_ctrl.sv
// Self-checking bench for mips_cpu_div_ctrl. The bench models the divider and
// predicts HI/LO from plain signed/unsigned arithmetic.
module tb_mips_cpu_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_signed, mthi_en, mtlo_en, hilo_rd;
  logic [31:0] op_a, op_b, wdata;
  logic [31:0] hi, lo;
  logic        busy, stall;
`ifdef MIPS_DIV_DBZ_STICKY_EN
  logic        dbz_sticky;
`endif

  mips_cpu_div_ctrl_if #(.WIDTH(32)) div_bus ();

  mips_cpu_div_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_signed (op_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .mthi_en   (mthi_en),
    .mtlo_en   (mtlo_en),
    .wdata     (wdata),
    .hilo_rd   (hilo_rd),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall     (stall),
`ifdef MIPS_DIV_DBZ_STICKY_EN
    .dbz_sticky(dbz_sticky),
`endif
    .div       (div_bus)
  );

  always #5 clk = ~clk;

  // Divider model: done stays high (stale) for the cycle after start, then rises lat_next cycles later
  int unsigned lat_next = 0;
  int unsigned cnt;
  logic        run;
  always @(posedge clk) begin
    if (reset) begin
      run                   <= 1'b0;
      cnt                   <= 0;
      div_bus.div_done      <= 1'b0;
      div_bus.div_dbz       <= 1'b0;
      div_bus.div_quotient  <= '0;
      div_bus.div_remainder <= '0;
    end else if (div_bus.div_start) begin
      run <= 1'b1;
      cnt <= lat_next;
    end else if (run) begin
      if (cnt == 0) begin
        run              <= 1'b0;
        div_bus.div_done <= 1'b1;
        div_bus.div_dbz  <= (div_bus.div_divisor == 0);
        if (div_bus.div_divisor == 0) begin
          div_bus.div_quotient  <= '1;
          div_bus.div_remainder <= div_bus.div_dividend;
        end else begin
          div_bus.div_quotient  <= div_bus.div_dividend / div_bus.div_divisor;
          div_bus.div_remainder <= div_bus.div_dividend % div_bus.div_divisor;
        end
      end else begin
        div_bus.div_done <= 1'b0;
        cnt              <= cnt - 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = '0, lo_m = '0;
  logic        sticky_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic s, input logic [31:0] x);
    longint v;
    v = s ? longint'($signed(x)) : longint'(x);
    if (v < 0) v = -v;
    return v[31:0];
  endfunction

  // Architectural result of DIV/DIVU on the model's HI/LO
  task automatic ref_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) begin
`ifdef MIPS_DIV_DBZ_STICKY_EN
      hi_m     = a;
      lo_m     = '1;
      sticky_m = 1'b1;
`endif
    end else begin
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      q  = sa / sb;
      r  = sa % sb;
      lo_m     = q[31:0];
      hi_m     = r[31:0];
      sticky_m = 1'b0;
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".hi"}, hi, hi_m);
    check({tag, ".lo"}, lo, lo_m);
`ifdef MIPS_DIV_DBZ_STICKY_EN
    check({tag, ".sticky"}, {31'b0, dbz_sticky}, {31'b0, sticky_m});
`endif
  endtask

  // Issue one divide (optionally with an MT* write the same cycle) from IDLE at a negedge
  task automatic issue_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input int unsigned lat, input logic [1:0] mt,
                           input logic [31:0] wd, input string tag);
    int cyc, starts;
    lat_next  = lat;
    op_valid  = 1'b1;
    op_signed = s;
    op_a      = a;
    op_b      = b;
    mthi_en   = mt[1];
    mtlo_en   = mt[0];
    wdata     = wd;
    if (mt[1]) begin hi_m = wd; sticky_m = 1'b0; end
    if (mt[0]) begin lo_m = wd; sticky_m = 1'b0; end
    @(negedge clk);
    op_valid = 1'b0;
    mthi_en  = 1'b0;
    mtlo_en  = 1'b0;
    check({tag, ".dividend"}, div_bus.div_dividend, mag(s, a));
    check({tag, ".divisor"}, div_bus.div_divisor, mag(s, b));
    cyc    = 0;
    starts = 0;
    while (busy && cyc < 200) begin
      if (div_bus.div_start) starts++;
      cyc++;
      @(negedge clk);
    end
    check({tag, ".busy_cycles"}, cyc, lat + 4);
    check({tag, ".start_pulses"}, starts, 1);
    ref_op(s, a, b);
    check_regs(tag);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom_range(0, 20);
      3:       return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold;
    int n;
    reset = 1'b1; op_valid = 1'b0; op_signed = 1'b0; op_a = '0; op_b = '0;
    mthi_en = 1'b0; mtlo_en = 1'b0; wdata = '0; hilo_rd = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.hi", hi, 32'h0);
    check("rst.lo", lo, 32'h0);
    check("rst.busy", {31'b0, busy}, 32'h0);
    check("rst.start", {31'b0, div_bus.div_start}, 32'h0);
    check("rst.dividend", div_bus.div_dividend, 32'h0);
    reset = 1'b0;

    // MTHI and MTLO together in IDLE
    mthi_en = 1'b1; mtlo_en = 1'b1; wdata = 32'h55;
    @(negedge clk);
    mtlo_en = 1'b0; wdata = 32'h1234;
    mthi_en = 1'b0; mtlo_en = 1'b1;
    @(negedge clk);
    mtlo_en = 1'b0;
    hi_m = 32'h55; lo_m = 32'h1234;
    check_regs("mt");

    // Reset while waiting on a long divide aborts cleanly
    lat_next = 10; op_valid = 1'b1; op_signed = 1'b0; op_a = 100; op_b = 7;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort.busy_before", {31'b0, busy}, 32'h1);
    check("abort.dividend_before", div_bus.div_dividend, 32'd100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hi_m = '0; lo_m = '0; sticky_m = 1'b0;
    check("abort.busy", {31'b0, busy}, 32'h0);
    check("abort.start", {31'b0, div_bus.div_start}, 32'h0);
    check("abort.divisor", div_bus.div_divisor, 32'h0);
    check_regs("abort");
    issue_div(1'b0, 32'd100, 32'd7, 3, 2'b00, '0, "divu100_7");

    // Directed divides including sign and overflow corners
    issue_div(1'b0, 32'hFFFF_FFFF, 32'h10, 5, 2'b00, '0, "divu_ffff_10");
    issue_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 2'b00, '0, "div_m7_2");
    issue_div(1'b1, 32'd7, 32'hFFFF_FFFE, 2, 2'b00, '0, "div_7_m2");
    issue_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 2'b00, '0, "div_ovf");

    // Divide by zero after MTLO
    mtlo_en = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    mtlo_en = 1'b0;
    lo_m = 32'h1234; sticky_m = 1'b0;
    issue_div(1'b0, 32'd5, 32'd0, 2, 2'b00, '0, "divu_5_0");
`ifdef MIPS_DIV_DBZ_STICKY_EN
    mthi_en = 1'b1; wdata = 32'h77;
    @(negedge clk);
    mthi_en = 1'b0;
    hi_m = 32'h77; sticky_m = 1'b0;
    check_regs("mthi_clears_sticky");
`endif

    // Requests held during busy must stall and leave HI untouched
    lat_next = 2; op_valid = 1'b1; op_signed = 1'b0; op_a = 9; op_b = 3;
    @(negedge clk);
    op_valid = 1'b0; hilo_rd = 1'b1; mthi_en = 1'b1; wdata = 32'hAA;
    hold = hi_m;
    n = 0;
    while (busy && n < 200) begin
      check("hold.stall", {31'b0, stall}, 32'h1);
      check("hold.hi", hi, hold);
      n++;
      @(negedge clk);
    end
    check("hold.cycles", n, 6);
    check("hold.stall_idle", {31'b0, stall}, 32'h0);
    ref_op(1'b0, 32'd9, 32'd3);
    check_regs("hold.div");
    @(negedge clk);
    mthi_en = 1'b0; hilo_rd = 1'b0;
    hi_m = 32'hAA; sticky_m = 1'b0;
    check_regs("hold.mthi");

    // Randomized divides with random latency and occasional same-cycle MT* writes
    for (int i = 0; i < 40; i++) begin
      logic [1:0] mt;
      mt = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      issue_div(1'($urandom_range(0, 1)), pick(), pick(), $urandom_range(0, 6), mt,
                $urandom(), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
